// File: rtl/time_entry_ctrl.sv
// Keypad front end for the microwave MM:SS timer: collects BCD digits, validates on start,
// then sequences the down-counters through load, count and end-of-cook.
module time_entry_ctrl #(
  parameter int unsigned QUICK_MIN    = 0,
  parameter int unsigned QUICK_SEC    = 30,
  parameter int unsigned SEC_TENS_MAX = 5
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       key_valid_i,
  input  logic [3:0] key_digit_i,
  input  logic       key_clear_i,
  input  logic       start_req_i,
  input  logic       door_open_i,
  input  logic       count_zero_i,
  output logic [3:0] sec_units_o,
  output logic [3:0] sec_tens_o,
  output logic [3:0] min_units_o,
  output logic [3:0] min_tens_o,
  output logic       load_n_o,
  output logic       count_en_o,
  output logic       clear_n_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int unsigned DW         = 4;
  localparam int unsigned CW         = 3;
  localparam int unsigned MAX_DIGITS = 4;

  localparam logic [DW-1:0] QMIN_TENS    = DW'(QUICK_MIN / 10);
  localparam logic [DW-1:0] QMIN_UNITS   = DW'(QUICK_MIN % 10);
  localparam logic [DW-1:0] QSEC_TENS    = DW'(QUICK_SEC / 10);
  localparam logic [DW-1:0] QSEC_UNITS   = DW'(QUICK_SEC % 10);
  localparam logic [DW-1:0] SEC_TENS_LIM = DW'(SEC_TENS_MAX);
  localparam logic [DW-1:0] BCD_MAX      = DW'(9);
  localparam logic [CW-1:0] CNT_FULL     = CW'(MAX_DIGITS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] su_q, su_d, st_q, st_d, mu_q, mu_d, mt_q, mt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_n_q, load_n_d;
  logic          count_en_q, count_en_d;
  logic          clear_n_q, clear_n_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic key_ok_c;
  logic entry_bad_c;

  assign key_ok_c    = key_valid_i && (key_digit_i <= BCD_MAX);
  assign entry_bad_c = (st_q > SEC_TENS_LIM) ||
                       ((mt_q == '0) && (mu_q == '0) && (st_q == '0) && (su_q == '0));

  // Next-state and registered-output logic; outputs follow the state they were computed in.
  always_comb begin
    state_d    = state_q;
    su_d       = su_q;
    st_d       = st_q;
    mu_d       = mu_q;
    mt_d       = mt_q;
    cnt_d      = cnt_q;
    load_n_d   = 1'b1;
    count_en_d = 1'b0;
    clear_n_d  = 1'b1;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (key_clear_i) begin
          state_d = IDLE;
        end else if (start_req_i) begin
          mt_d    = QMIN_TENS;
          mu_d    = QMIN_UNITS;
          st_d    = QSEC_TENS;
          su_d    = QSEC_UNITS;
          state_d = LOAD;
        end else if (key_ok_c) begin
          mt_d    = mu_q;
          mu_d    = st_q;
          st_d    = su_q;
          su_d    = key_digit_i;
          cnt_d   = cnt_q + CW'(1);
          state_d = ENTRY;
        end
      end

      ENTRY: begin
        if (key_clear_i) begin
          {mt_d, mu_d, st_d, su_d} = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (start_req_i) begin
          if (entry_bad_c) begin
            err_d = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end else if (key_ok_c && (cnt_q < CNT_FULL)) begin
          mt_d  = mu_q;
          mu_d  = st_q;
          st_d  = su_q;
          su_d  = key_digit_i;
          cnt_d = cnt_q + CW'(1);
        end
      end

      LOAD: begin
        load_n_d = 1'b0;
        state_d  = RUN;
      end

      // load_n_q is still low in the first RUN cycle, when the counters have not yet loaded.
      RUN: begin
        if (key_clear_i) begin
          clear_n_d = 1'b0;
          {mt_d, mu_d, st_d, su_d} = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (count_zero_i && load_n_q) begin
          state_d = DONE;
        end else begin
          count_en_d = ~door_open_i;
        end
      end

      DONE: begin
        done_d = 1'b1;
        {mt_d, mu_d, st_d, su_d} = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      su_q       <= '0;
      st_q       <= '0;
      mu_q       <= '0;
      mt_q       <= '0;
      cnt_q      <= '0;
      load_n_q   <= 1'b1;
      count_en_q <= 1'b0;
      clear_n_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      su_q       <= su_d;
      st_q       <= st_d;
      mu_q       <= mu_d;
      mt_q       <= mt_d;
      cnt_q      <= cnt_d;
      load_n_q   <= load_n_d;
      count_en_q <= count_en_d;
      clear_n_q  <= clear_n_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign sec_units_o = su_q;
  assign sec_tens_o  = st_q;
  assign min_units_o = mu_q;
  assign min_tens_o  = mt_q;
  assign load_n_o    = load_n_q;
  assign count_en_o  = count_en_q;
  assign clear_n_o   = clear_n_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_time_entry_ctrl.sv
// Directed, table-driven bench for time_entry_ctrl with hand-computed expected outputs.
module tb_time_entry_ctrl;

  logic       clk;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       key_clear;
  logic       start_req;
  logic       door_open;
  logic       count_zero;
  logic [3:0] sec_units, sec_tens, min_units, min_tens;
  logic       load_n, count_en, clear_n, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  time_entry_ctrl dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .key_valid_i  (key_valid),
    .key_digit_i  (key_digit),
    .key_clear_i  (key_clear),
    .start_req_i  (start_req),
    .door_open_i  (door_open),
    .count_zero_i (count_zero),
    .sec_units_o  (sec_units),
    .sec_tens_o   (sec_tens),
    .min_units_o  (min_units),
    .min_tens_o   (min_tens),
    .load_n_o     (load_n),
    .count_en_o   (count_en),
    .clear_n_o    (clear_n),
    .done_o       (done),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       kv;
    logic [3:0] kd;
    logic       kc;
    logic       sr;
    logic       door;
    logic       cz;
    logic [15:0] digits;   // {min_tens, min_units, sec_tens, sec_units}
    logic [4:0]  ctrl;     // {load_n, count_en, clear_n, done, err}
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic kv, input logic [3:0] kd, input logic kc,
                              input logic sr, input logic door, input logic cz,
                              input logic [15:0] digits, input logic [4:0] ctrl);
    vec_t v;
    v.kv = kv; v.kd = kd; v.kc = kc; v.sr = sr; v.door = door; v.cz = cz;
    v.digits = digits; v.ctrl = ctrl;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later; invariants are checked every cycle.
  task automatic step();
    @(posedge clk);
    #1;
    check("load_n/clear_n overlap", 32'(!load_n && !clear_n), 32'd0);
    check("done/err overlap", 32'(done && err), 32'd0);
  endtask

  task automatic drive(input logic kv, input logic [3:0] kd, input logic kc,
                       input logic sr, input logic door, input logic cz);
    key_valid = kv; key_digit = kd; key_clear = kc;
    start_req = sr; door_open = door; count_zero = cz;
  endtask

  function automatic logic [15:0] cur_digits();
    return {min_tens, min_units, sec_tens, sec_units};
  endfunction

  function automatic logic [4:0] cur_ctrl();
    return {load_n, count_en, clear_n, done, err};
  endfunction

  localparam logic [4:0] C_IDLE = 5'b10100;  // load_n=1, count_en=0, clear_n=1
  localparam logic [4:0] C_LOAD = 5'b00100;
  localparam logic [4:0] C_RUN  = 5'b11100;
  localparam logic [4:0] C_DONE = 5'b10110;
  localparam logic [4:0] C_ERR  = 5'b10101;
  localparam logic [4:0] C_CLR  = 5'b10000;

  initial begin
    int lat;

    // Scenario 1: 12:30 entry, load, run, end of cook (first-RUN count_zero ignored)
    tbl.push_back(mk(1, 4'd1, 0, 0, 0, 0, 16'h0001, C_IDLE));
    tbl.push_back(mk(1, 4'd2, 0, 0, 0, 0, 16'h0012, C_IDLE));
    tbl.push_back(mk(1, 4'd3, 0, 0, 0, 0, 16'h0123, C_IDLE));
    tbl.push_back(mk(1, 4'd0, 0, 0, 0, 0, 16'h1230, C_IDLE));
    tbl.push_back(mk(0, 4'd0, 0, 1, 0, 0, 16'h1230, C_IDLE));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 16'h1230, C_LOAD));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 1, 16'h1230, C_RUN));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 16'h1230, C_RUN));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 1, 16'h1230, C_IDLE));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 16'h0000, C_DONE));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 16'h0000, C_IDLE));
    // Scenario 2: 9,8,B,7,6,5 -> 98:76; start rejected (sec tens 7); key+clear -> clear wins
    tbl.push_back(mk(1, 4'd9, 0, 0, 0, 0, 16'h0009, C_IDLE));
    tbl.push_back(mk(1, 4'd8, 0, 0, 0, 0, 16'h0098, C_IDLE));
    tbl.push_back(mk(1, 4'hB, 0, 0, 0, 0, 16'h0098, C_IDLE));
    tbl.push_back(mk(1, 4'd7, 0, 0, 0, 0, 16'h0987, C_IDLE));
    tbl.push_back(mk(1, 4'd6, 0, 0, 0, 0, 16'h9876, C_IDLE));
    tbl.push_back(mk(1, 4'd5, 0, 0, 0, 0, 16'h9876, C_IDLE));
    tbl.push_back(mk(0, 4'd0, 0, 1, 0, 0, 16'h9876, C_ERR));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 16'h9876, C_IDLE));
    tbl.push_back(mk(1, 4'd4, 1, 0, 0, 0, 16'h0000, C_IDLE));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 16'h0000, C_IDLE));
    // Scenario 3: 1:75 rejected, no load pulse, then clear
    tbl.push_back(mk(1, 4'd1, 0, 0, 0, 0, 16'h0001, C_IDLE));
    tbl.push_back(mk(1, 4'd7, 0, 0, 0, 0, 16'h0017, C_IDLE));
    tbl.push_back(mk(1, 4'd5, 0, 0, 0, 0, 16'h0175, C_IDLE));
    tbl.push_back(mk(0, 4'd0, 0, 1, 0, 0, 16'h0175, C_ERR));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 16'h0175, C_IDLE));
    tbl.push_back(mk(0, 4'd0, 1, 0, 0, 0, 16'h0000, C_IDLE));
    // Scenario 4: quick start 00:30, door pauses 3 cycles, clear aborts without done
    tbl.push_back(mk(0, 4'd0, 0, 1, 0, 0, 16'h0030, C_IDLE));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 16'h0030, C_LOAD));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 16'h0030, C_RUN));
    tbl.push_back(mk(0, 4'd0, 0, 0, 1, 0, 16'h0030, C_IDLE));
    tbl.push_back(mk(0, 4'd0, 0, 0, 1, 0, 16'h0030, C_IDLE));
    tbl.push_back(mk(0, 4'd0, 0, 0, 1, 0, 16'h0030, C_IDLE));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 16'h0030, C_RUN));
    tbl.push_back(mk(1, 4'd3, 1, 1, 0, 0, 16'h0000, C_CLR));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 16'h0000, C_IDLE));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 16'h0000, C_IDLE));
    // Scenario 5: 00:00 entered -> start rejected
    tbl.push_back(mk(1, 4'd0, 0, 0, 0, 0, 16'h0000, C_IDLE));
    tbl.push_back(mk(1, 4'd0, 0, 0, 0, 0, 16'h0000, C_IDLE));
    tbl.push_back(mk(0, 4'd0, 0, 1, 0, 0, 16'h0000, C_ERR));
    tbl.push_back(mk(0, 4'd0, 0, 0, 0, 0, 16'h0000, C_IDLE));
    tbl.push_back(mk(0, 4'd0, 1, 0, 0, 0, 16'h0000, C_IDLE));

    reset = 1'b1;
    drive(0, 4'd0, 0, 0, 0, 0);
    step();
    check("reset digits", 32'(cur_digits()), 32'h0000);
    check("reset ctrl", 32'(cur_ctrl()), 32'(C_CLR));
    step();
    check("reset ctrl hold", 32'(cur_ctrl()), 32'(C_CLR));
    reset = 1'b0;
    step();
    check("post-reset ctrl", 32'(cur_ctrl()), 32'(C_IDLE));

    foreach (tbl[i]) begin
      drive(tbl[i].kv, tbl[i].kd, tbl[i].kc, tbl[i].sr, tbl[i].door, tbl[i].cz);
      step();
      check($sformatf("vec%0d digits", i), 32'(cur_digits()), 32'(tbl[i].digits));
      check($sformatf("vec%0d ctrl", i), 32'(cur_ctrl()), 32'(tbl[i].ctrl));
    end
    drive(0, 4'd0, 0, 0, 0, 0);

    // Reset held two cycles mid-RUN
    drive(1, 4'd2, 0, 0, 0, 0); step();
    drive(0, 4'd0, 0, 1, 0, 0); step();
    drive(0, 4'd0, 0, 0, 0, 0); step();
    check("rst seq load", 32'(cur_ctrl()), 32'(C_LOAD));
    step();
    check("rst seq run", 32'(cur_ctrl()), 32'(C_RUN));
    reset = 1'b1;
    step();
    check("rst run c1 ctrl", 32'(cur_ctrl()), 32'(C_CLR));
    check("rst run c1 digits", 32'(cur_digits()), 32'h0000);
    step();
    check("rst run c2 ctrl", 32'(cur_ctrl()), 32'(C_CLR));
    reset = 1'b0;
    step();
    check("rst release ctrl", 32'(cur_ctrl()), 32'(C_IDLE));

    // Quick start with count_zero held high: done expected 5 edges after the start edge
    drive(0, 4'd0, 0, 1, 0, 1);
    step();
    drive(0, 4'd0, 0, 0, 0, 1);
    lat = 0;
    for (int c = 2; c <= 20; c++) begin
      step();
      if (done) begin
        lat = c;
        break;
      end
    end
    check("done latency", 32'(lat), 32'd5);
    check("done digits", 32'(cur_digits()), 32'h0000);
    drive(0, 4'd0, 0, 0, 0, 0);
    step();
    check("done one-shot", 32'(done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/time_entry_ctrl.md
Name: time_entry_ctrl

Overview:
- Keypad-side front end of the microwave timer; sits directly upstream of the four chained BCD down-counter digits (MM:SS).
- Collects keypad digits into a 4-digit BCD entry register and validates the entry on start.
- Drives the counters' parallel data and active-low load strobe, then their count-enable and active-low clear.
- Watches the chained zero flag to detect end of cook.

Parameters:
QUICK_MIN, 0, minutes loaded by start with an empty entry (0..99, decimal).
QUICK_SEC, 30, seconds loaded by start with an empty entry (0..59, decimal).
SEC_TENS_MAX, 5, largest legal seconds-tens digit; larger values reject start.

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-high; returns block to IDLE.
key_valid  in  1  one-cycle strobe, key_digit valid.
key_digit  in  4  BCD keypad digit; codes above 9 are ignored.
key_clear  in  1  one-cycle strobe: cancel entry or abort cook.
start_req  in  1  one-cycle strobe: start cook.
door_open  in  1  level; pauses counting while high.
count_zero  in  1  AND of all counter digit terminal-count flags (all digits 0).
sec_units, sec_tens, min_units, min_tens  out  4 each  entry digits, wired to counter data inputs.
load_n  out  1  active-low one-cycle parallel-load strobe to counters.
count_en  out  1  counter stop input; 1 = count, 0 = hold.
clear_n  out  1  active-low counter clear.
done  out  1  one-cycle pulse at end of cook.
err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset values:
  - All digits 0, digit count 0, state IDLE.
  - load_n=1, count_en=0, done=0, err=0.
  - clear_n=0 during any cycle reset is sampled high; clear_n=1 on the first cycle after reset deasserts.
- State IDLE (entry empty):
  - A valid digit (key_valid, key_digit<=9) shifts in and moves to ENTRY.
  - start_req loads QUICK_MIN:QUICK_SEC, converted to BCD, into the digits and moves to LOAD.
  - key_clear has no effect.
- Digit shift: min_tens<=min_units, min_units<=sec_tens, sec_tens<=sec_units, sec_units<=key_digit. Digit count increments.
- State ENTRY:
  - Once digit count reaches 4, further digits are ignored; nothing shifts.
  - key_digit>9 is ignored.
  - key_clear zeroes the digits and count, then returns to IDLE.
  - start_req with sec_tens>SEC_TENS_MAX or all digits 0: err pulses one cycle; stay in ENTRY with digits unchanged.
  - Otherwise start_req moves to LOAD.
- Priority in one cycle: key_clear > start_req > key_valid. A digit arriving with start or clear is dropped.
- State LOAD: exactly one cycle. load_n=0, count_en=0. Next state RUN. Keys are ignored.
- State RUN:
  - count_en = ~door_open, registered, so it changes one cycle after door_open.
  - key_valid and start_req are ignored.
  - key_clear drives clear_n=0 for one cycle and count_en=0; digits and count are zeroed; go to IDLE, with no done pulse.
  - count_zero=1 while in RUN (any cycle after the first RUN cycle) moves to DONE. count_en drops to 0 on the same edge.
- State DONE: one cycle. done=1, digits and count zeroed, next state IDLE.
- load_n and clear_n are never low in the same cycle. done and err are never high in the same cycle.
- Reset mid-RUN: immediate IDLE, clear_n low, no done pulse.

Test Plan:
- Keys 1,2,3,0 then start_req -> digits 1,2:3,0.
  - load_n low exactly one cycle, two cycles after the start edge; count_en=1 next cycle.
  - Force count_zero=1 -> done one cycle, count_en=0, state IDLE, digits 0.
- Keys 9,8,7,6,5 -> digits 9,8:7,6 (fifth key ignored).
  - Key code 0xB mid-entry -> no shift.
- Keys 1,7,5 (1:75) then start_req -> err one cycle, no load_n pulse, digits unchanged.
  - Then key_clear -> IDLE, digits 0.
- start_req from IDLE with defaults -> digits 0,0:3,0 and load_n pulse.
  - Also: start with 00:00 entered (keys 0,0) -> err.
- In RUN, door_open=1 for 3 cycles -> count_en 0 for 3 cycles, delayed one cycle.
  - key_clear in RUN -> clear_n low one cycle, no done, IDLE.
  - key_valid+key_clear in the same cycle in ENTRY -> clear wins.
- reset asserted in RUN for 2 cycles -> clear_n=0 both cycles, count_en=0, load_n=1; clear_n=1 on the first cycle after release.
